ascon_perm_scheduler: RTL and testbench
=======================================

ASCON_PERM_SCHEDULER -- requirements
Module: ascon_perm_scheduler

Interface
REQ-001 The block SHALL have parameter ROUNDS_A, default 12, giving the p^a round count (init/finalization); legal range 1..12.
REQ-002 The block SHALL have parameter ROUNDS_B, default 6, giving the p^b round count (data; 8 for Ascon-128a); legal range 1..12.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port req0_valid  input  1  requester 0 wants one permutation.
REQ-006 The block SHALL have port req0_sel_b  input  1  requester 0 round select: 0 = ROUNDS_A, 1 = ROUNDS_B.
REQ-007 The block SHALL have port req0_ready  output  1  requester 0 grant; a transfer occurs when valid and ready are both high.
REQ-008 The block SHALL have port req0_done  output  1  one-cycle pulse: requester 0 permutation complete.
REQ-009 The block SHALL have ports req1_valid, req1_sel_b, req1_ready, req1_done, identical to REQ-005..008 for requester 1.
REQ-010 The block SHALL have port perm_start  output  1  level held high for exactly n cycles while the permutation datapath runs.
REQ-011 The block SHALL have port perm_round  output  5  current round index 0..n-1; 0 when idle.
REQ-012 The block SHALL have port perm_rc_idx  output  4  round-constant index = 12 - n + perm_round; 0 when idle.
REQ-013 The block SHALL have port perm_first  output  1  high in the first round cycle (datapath loads the owner's state).
REQ-014 The block SHALL have port perm_last  output  1  high in the last round cycle (round n-1).
REQ-015 The block SHALL have port perm_owner  output  1  index of the requester being served; holds its last value when idle.
REQ-016 The block SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE; IDLE->RUN on a transfer; RUN->DONE after the perm_last cycle; DONE->IDLE unconditionally.
REQ-018 In IDLE, ready SHALL be driven combinationally to at most one requester, the arbitration winner among those with valid high; both readys are low in RUN and DONE.
REQ-019 Arbitration SHALL be round-robin: a single requester wins alone; on a tie, the requester not granted last wins; after reset, requester 0 wins the first tie.
REQ-020 On a transfer, the block SHALL latch owner and n (ROUNDS_A or ROUNDS_B per sel_b), and SHALL set perm_round to 0.
REQ-021 Latency: transfer in cycle T; perm_start high T+1..T+n; perm_first at T+1; perm_last at T+n; owner's done at T+n+1; next grant no earlier than T+n+2.
REQ-022 In RUN, perm_round SHALL increment by 1 per cycle and SHALL never exceed n-1; there is no wrap.
REQ-023 With n = 1, perm_first and perm_last SHALL both be high in the same single RUN cycle.
REQ-024 Only the owner's done SHALL pulse; the other requester's done stays 0.
REQ-025 A valid dropped before ready is a withdrawn request; no state change results.
REQ-026 sel_b and valid changes after acceptance SHALL have no effect on the running permutation.
REQ-027 A requester holding valid through DONE SHALL be eligible for arbitration in the following IDLE cycle.

Reset
REQ-028 With rst low at a clock edge, the block SHALL enter IDLE, and all outputs SHALL be 0, including perm_owner and the round-robin pointer (last grant = 1).
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort immediately: no done pulse, perm_start 0 the cycle after the edge, and the pending request is lost.
REQ-030 While rst is low, ready SHALL stay 0, and valid inputs SHALL be ignored.

Verification
REQ-031 Single p^a: req0_valid=1, sel_b=0 at T -> req0_ready=1 at T; perm_start high T+1..T+12; perm_rc_idx 0..11; req0_done at T+13.
REQ-032 Single p^b: req1_valid=1, sel_b=1 -> perm_start 6 cycles; perm_rc_idx 6..11; perm_first and perm_last each 1 cycle; req1_done only.
REQ-033 Tie after reset: both valid, hold -> grants in order 0, 1, 0, 1; each done goes to its matching requester; idle cycle between services.
REQ-034 Reset mid-run: assert rst low at round 5 of p^a -> next cycle busy=0, perm_start=0, perm_round=0; no done pulse; ready returns in IDLE.
REQ-035 Edge parameters: ROUNDS_B=1 -> perm_first=perm_last=1 in one cycle, perm_rc_idx=11; ROUNDS_B=8 -> perm_rc_idx 4..11.
REQ-036 Ignored inputs: toggle sel_b and drop valid during RUN -> round count and owner unchanged; a withdrawn pre-grant valid produces no grant.

Source files
------------

// File: rtl/ascon_perm_scheduler.sv
// Round-robin scheduler sharing one Ascon permutation datapath between two requesters.
// Grant is combinational in IDLE; a granted permutation runs n cycles, then a done pulse and one idle gap.
module ascon_perm_scheduler #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req0_sel_b,
  output logic       req0_ready,
  output logic       req0_done,
  input  logic       req1_valid,
  input  logic       req1_sel_b,
  output logic       req1_ready,
  output logic       req1_done,
  output logic       perm_start,
  output logic [4:0] perm_round,
  output logic [3:0] perm_rc_idx,
  output logic       perm_first,
  output logic       perm_last,
  output logic       perm_owner,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] N_A = 5'(ROUNDS_A);
  localparam logic [4:0] N_B = 5'(ROUNDS_B);

  logic [1:0] state;
  logic       owner;
  logic       last_grant;
  logic [4:0] n_rounds;
  logic [4:0] round;
  logic       gnt0;
  logic       gnt1;
  logic       xfer;
  logic       win_sel_b;
  logic       in_run;
  logic       at_last;
  logic [3:0] rc_idx;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == S_IDLE && rst) begin
      if (req0_valid && req1_valid) begin
        if (last_grant) gnt0 = 1'b1;
        else            gnt1 = 1'b1;
      end else if (req0_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign xfer      = gnt0 | gnt1;
  assign win_sel_b = gnt1 ? req1_sel_b : req0_sel_b;
  assign in_run    = (state == S_RUN);
  assign at_last   = (round == n_rounds - 5'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      n_rounds   <= 5'd0;
      round      <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (xfer) begin
            state      <= S_RUN;
            owner      <= gnt1;
            last_grant <= gnt1;
            n_rounds   <= win_sel_b ? N_B : N_A;
            round      <= 5'd0;
          end
        end
        S_RUN: begin
          if (at_last) begin
            state <= S_DONE;
            round <= 5'd0;
          end else begin
            round <= round + 5'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result never exceeds 11, so 4-bit wraparound arithmetic is exact.
  assign rc_idx = 4'd12 - n_rounds[3:0] + round[3:0];

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign req0_done   = (state == S_DONE) && !owner;
  assign req1_done   = (state == S_DONE) && owner;
  assign perm_start  = in_run;
  assign perm_round  = round;
  assign perm_rc_idx = in_run ? rc_idx : 4'd0;
  assign perm_first  = in_run && (round == 5'd0);
  assign perm_last   = in_run && at_last;
  assign perm_owner  = owner;
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_ascon_perm_scheduler.sv
// Directed bench: default instance plus ROUNDS_B=1 and ROUNDS_B=8 instances on a separate reset.
module tb_ascon_perm_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_e = 1'b0;
  logic req0_valid = 1'b0, req0_sel_b = 1'b0, req1_valid = 1'b0, req1_sel_b = 1'b0;

  logic [2:0]      rdy0, rdy1, dn0, dn1, start, first, last, owner, busy;
  logic [2:0][4:0] rnd;
  logic [2:0][3:0] rc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ascon_perm_scheduler u_def (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_sel_b(req0_sel_b), .req0_ready(rdy0[0]), .req0_done(dn0[0]),
    .req1_valid(req1_valid), .req1_sel_b(req1_sel_b), .req1_ready(rdy1[0]), .req1_done(dn1[0]),
    .perm_start(start[0]), .perm_round(rnd[0]), .perm_rc_idx(rc[0]), .perm_first(first[0]),
    .perm_last(last[0]), .perm_owner(owner[0]), .busy(busy[0])
  );

  ascon_perm_scheduler #(.ROUNDS_B(1)) u_b1 (
    .clk(clk), .rst(rst_e),
    .req0_valid(req0_valid), .req0_sel_b(req0_sel_b), .req0_ready(rdy0[1]), .req0_done(dn0[1]),
    .req1_valid(req1_valid), .req1_sel_b(req1_sel_b), .req1_ready(rdy1[1]), .req1_done(dn1[1]),
    .perm_start(start[1]), .perm_round(rnd[1]), .perm_rc_idx(rc[1]), .perm_first(first[1]),
    .perm_last(last[1]), .perm_owner(owner[1]), .busy(busy[1])
  );

  ascon_perm_scheduler #(.ROUNDS_B(8)) u_b8 (
    .clk(clk), .rst(rst_e),
    .req0_valid(req0_valid), .req0_sel_b(req0_sel_b), .req0_ready(rdy0[2]), .req0_done(dn0[2]),
    .req1_valid(req1_valid), .req1_sel_b(req1_sel_b), .req1_ready(rdy1[2]), .req1_done(dn1[2]),
    .perm_start(start[2]), .perm_round(rnd[2]), .perm_rc_idx(rc[2]), .perm_first(first[2]),
    .perm_last(last[2]), .perm_owner(owner[2]), .busy(busy[2])
  );

  typedef struct {
    bit v0, s0, v1, s1;
    bit er0, er1;
    bit own;
    int n;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // {start, round, rc_idx, first, last, done0, done1, busy}
  function automatic logic [14:0] snap(input int i);
    return {start[i], rnd[i], rc[i], first[i], last[i], dn0[i], dn1[i], busy[i]};
  endfunction

  // Expected snapshot k cycles after the transfer edge for an n-round permutation.
  function automatic logic [14:0] exp_snap(input int n, input int k, input bit own);
    if (k >= 1 && k <= n)
      return {1'b1, 5'(k - 1), 4'(12 - n + k - 1), (k == 1), (k == n), 2'b00, 1'b1};
    else if (k == n + 1)
      return {1'b0, 5'd0, 4'd0, 1'b0, 1'b0, (own == 1'b0), (own == 1'b1), 1'b1};
    else
      return 15'd0;
  endfunction

  task automatic run_txn(input vec_t v, input int idx);
    req0_valid = v.v0; req0_sel_b = v.s0;
    req1_valid = v.v1; req1_sel_b = v.s1;
    #1;
    chk($sformatf("v%0d ready0", idx), 32'(rdy0[0]), 32'(v.er0));
    chk($sformatf("v%0d ready1", idx), 32'(rdy1[0]), 32'(v.er1));
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk($sformatf("v%0d owner", idx), 32'(owner[0]), 32'(v.own));
    for (int k = 1; k <= v.n + 2; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("v%0d k%0d", idx, k), 32'(snap(0)), 32'(exp_snap(v.n, k, v.own)));
    end
  endtask

  initial begin
    // tie after reset -> 0,1,0,1; then single requesters win alone regardless of pointer
    vt[0] = '{v0:1, s0:0, v1:1, s1:0, er0:1, er1:0, own:0, n:12};
    vt[1] = '{v0:1, s0:0, v1:1, s1:1, er0:0, er1:1, own:1, n:6};
    vt[2] = '{v0:1, s0:1, v1:1, s1:0, er0:1, er1:0, own:0, n:6};
    vt[3] = '{v0:1, s0:0, v1:1, s1:1, er0:0, er1:1, own:1, n:6};
    vt[4] = '{v0:0, s0:0, v1:1, s1:0, er0:0, er1:1, own:1, n:12};
    vt[5] = '{v0:1, s0:1, v1:0, s1:0, er0:1, er1:0, own:0, n:6};

    // reset with valids high: nothing granted, all outputs 0
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst ready0", 32'(rdy0[0]), 32'd0);
    chk("rst ready1", 32'(rdy1[0]), 32'd0);
    chk("rst outputs", 32'(snap(0)), 32'd0);
    chk("rst owner", 32'(owner[0]), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_txn(vt[i], i);

    // inputs toggled during the run are ignored; valid held through DONE wins next IDLE
    req1_valid = 1'b1; req1_sel_b = 1'b1;
    #1;
    chk("ign ready1", 32'(rdy1[0]), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("ign k%0d", k), 32'(snap(0)), 32'(exp_snap(6, k, 1'b1)));
      if (k <= 7) begin
        chk($sformatf("ign rdy k%0d", k), 32'({rdy0[0], rdy1[0]}), 32'd0);
        chk($sformatf("ign own k%0d", k), 32'(owner[0]), 32'd1);
      end else begin
        chk("hold-through-done ready0", 32'({rdy0[0], rdy1[0]}), 32'b10);
      end
      req0_valid = (k < 8);
      req0_sel_b = k[0];
      req1_valid = k[0] && (k < 8);
      req1_sel_b = ~k[0];
    end
    #1;

    // reset at round 5 of p^a aborts with no done pulse
    req0_valid = 1'b1; req0_sel_b = 1'b0;
    #1;
    chk("abort ready0", 32'(rdy0[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("abort k%0d", k), 32'(snap(0)), 32'(exp_snap(12, k, 1'b0)));
    end
    rst = 1'b0;
    @(negedge clk);
    chk("abort outputs", 32'(snap(0)), 32'd0);
    rst = 1'b1;
    // pointer was reset to last=1, so req0 must win the tie
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("abort ptr ready", 32'({rdy0[0], rdy1[0]}), 32'b10);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk($sformatf("withdrawn k%0d", k), 32'(snap(0)), 32'd0);
    end

    // ROUNDS_B edge values on the side instances
    rst_e = 1'b1;
    @(negedge clk);
    req1_valid = 1'b1; req1_sel_b = 1'b1;
    #1;
    chk("edge ready", 32'({rdy1[1], rdy1[2]}), 32'b11);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) @(negedge clk);
      chk($sformatf("b1 k%0d", k), 32'(snap(1)), 32'(exp_snap(1, k, 1'b1)));
      chk($sformatf("b8 k%0d", k), 32'(snap(2)), 32'(exp_snap(8, k, 1'b1)));
      chk($sformatf("b6 k%0d", k), 32'(snap(0)), 32'(exp_snap(6, k, 1'b1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
